// File: rtl/credit_pkg.sv
// Shared types and default sizing for the credit-return link.
// The conservation check relates receiver and sender state.
package credit_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 32;
  localparam int unsigned DEPTH_DEF        = 8;
  localparam int unsigned COUNT_SZ_DEF     = 10;
  localparam int unsigned CREDIT_BATCH_DEF = 4;
  localparam int unsigned FLUSH_CYCLES_DEF = 16;

  typedef logic [COUNT_SZ_DEF-1:0] credit_t;

  // Every credit is either a buffered word, pending here, or held by the sender.
  function automatic bit credit_conserved(input int unsigned occ,
                                          input int unsigned pending,
                                          input int unsigned sender,
                                          input int unsigned depth = DEPTH_DEF);
    return (occ + pending + sender) == depth;
  endfunction

endpackage

// File: rtl/credit_sink_if.sv
// Link between the credit sink, its sender (enq/credit) and its consumer (deq).
// slave is the sink side; master is the sender/consumer side.
interface credit_sink_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned COUNT_SZ   = 10
);
  logic                  enq__ENA;
  logic [DATA_WIDTH-1:0] enq_v;
  logic                  enq__RDY;
  logic [DATA_WIDTH-1:0] first;
  logic                  first__RDY;
  logic                  deq__ENA;
  logic                  deq__RDY;
  logic                  credit__ENA;
  logic [COUNT_SZ-1:0]   credit_v;
  logic                  credit__RDY;
  logic                  overflow;

  modport slave (
    input  enq__ENA, enq_v, deq__ENA, credit__RDY,
    output enq__RDY, first, first__RDY, deq__RDY, credit__ENA, credit_v, overflow
  );

  modport master (
    output enq__ENA, enq_v, deq__ENA, credit__RDY,
    input  enq__RDY, first, first__RDY, deq__RDY, credit__ENA, credit_v, overflow
  );
endinterface

// File: rtl/credit_sink_buf.sv
// Circular receive buffer with registered occupancy; DEPTH need not be a power of two.
// Full-with-dequeue accepts the enqueue since the head slot frees in the same cycle.
module credit_sink_buf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_enq,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_deq,
  output logic [DATA_WIDTH-1:0] o_first,
  output logic                  o_not_full,
  output logic                  o_not_empty,
  output logic                  o_deq_acc,
  output logic                  o_drop
);
  localparam int unsigned PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_rd;
  logic [PW-1:0]         r_wr;
  logic [OW-1:0]         r_occ;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_enq;
  logic                  w_deq;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full      = (r_occ == OW'(DEPTH));
  assign w_empty     = (r_occ == '0);
  assign w_deq       = i_deq & ~w_empty;
  assign w_enq       = i_enq & (~w_full | w_deq);
  assign o_drop      = i_enq & w_full & ~w_deq;
  assign o_deq_acc   = w_deq;
  assign o_not_full  = ~w_full;
  assign o_not_empty = ~w_empty;
  assign o_first     = w_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge CLK) begin
    if (w_enq) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_occ <= '0;
    end else begin
      if (w_enq) r_wr <= wrap_inc(r_wr);
      if (w_deq) r_rd <= wrap_inc(r_rd);
      unique case ({w_enq, w_deq})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/credit_sink.sv
// Credit-flow receiver: buffers sender words and returns freed slots as batched grants.
// Reset preloads DEPTH pending credits so the sender's counter can start at zero.
module credit_sink
  import credit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned COUNT_SZ     = COUNT_SZ_DEF,
  parameter int unsigned CREDIT_BATCH = CREDIT_BATCH_DEF,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  credit_sink_if.slave  link
);
  localparam int unsigned IW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  logic [COUNT_SZ-1:0] r_pending;
  logic [COUNT_SZ-1:0] w_pending_nxt;
  logic [IW-1:0]       r_idle;
  logic [IW-1:0]       w_idle_nxt;
  logic                r_overflow;
  logic                w_deq_acc;
  logic                w_drop;
  logic                w_not_empty;
  logic                w_batch;
  logic                w_flush;
  logic                w_fire;

  credit_sink_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buf (
    .CLK         (CLK),
    .RST         (RST),
    .i_enq       (link.enq__ENA),
    .i_data      (link.enq_v),
    .i_deq       (link.deq__ENA),
    .o_first     (link.first),
    .o_not_full  (link.enq__RDY),
    .o_not_empty (w_not_empty),
    .o_deq_acc   (w_deq_acc),
    .o_drop      (w_drop)
  );

  assign link.first__RDY = w_not_empty;
  assign link.deq__RDY   = w_not_empty;

  assign w_batch = (r_pending >= COUNT_SZ'(CREDIT_BATCH));
  assign w_flush = (FLUSH_CYCLES != 0) && (r_idle == IW'(FLUSH_CYCLES));
  assign w_fire  = link.credit__RDY && (r_pending != '0) && (w_batch || w_flush);

  // Pending is preloaded during reset, so the grant must be masked while RST is held.
  assign link.credit__ENA = w_fire & ~RST;
  assign link.credit_v    = r_pending;
  assign link.overflow    = r_overflow;

  always_comb begin
    w_pending_nxt = r_pending + COUNT_SZ'(w_deq_acc);
    w_idle_nxt    = r_idle;
    if (w_fire) begin
      // The same-cycle deq is carried into the next batch rather than lost.
      w_pending_nxt = COUNT_SZ'(w_deq_acc);
    end
    if (w_fire || (r_pending == '0)) begin
      w_idle_nxt = '0;
    end else if (r_idle != IW'(FLUSH_CYCLES)) begin
      w_idle_nxt = r_idle + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pending  <= COUNT_SZ'(DEPTH);
      r_idle     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_idle     <= w_idle_nxt;
      r_overflow <= r_overflow | w_drop;
    end
  end

endmodule

// File: tb/tb_credit_sink.sv
// Bench for credit_sink: vector rows with a data scoreboard plus grant-timing sequences.
module tb_credit_sink;
  import credit_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned CS = 10;

  typedef struct {
    logic          enq;
    logic [DW-1:0] data;
    logic          deq;
    logic          e_enq_rdy;
    logic          e_first_rdy;
    logic          e_cr_en;
    logic [CS-1:0] e_cr_v;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  credit_sink_if #(.DATA_WIDTH(DW), .COUNT_SZ(CS)) link();

  credit_sink #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH_DEF),
    .COUNT_SZ     (CS),
    .CREDIT_BATCH (CREDIT_BATCH_DEF),
    .FLUSH_CYCLES (FLUSH_CYCLES_DEF)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .link (link)
  );

  always #5 clk = ~clk;

  int n_chk     = 0;
  int n_fail    = 0;
  int tot_grant = 0;
  int tot_enq   = 0;
  int tot_deq   = 0;
  logic [DW-1:0] sb[$];
  vec_t tbl[14];

  // Grants are counted mid-cycle, away from the edge that consumes them.
  always @(negedge clk) begin
    if (rst) tot_grant = 0;
    else if (link.credit__ENA) tot_grant = tot_grant + int'(link.credit_v);
  end

  function automatic vec_t mk(input logic enq, input int unsigned data, input logic deq,
                              input logic er, input logic fr, input logic ce,
                              input int unsigned cv);
    vec_t v;
    v.enq = enq; v.data = DW'(data); v.deq = deq;
    v.e_enq_rdy = er; v.e_first_rdy = fr; v.e_cr_en = ce; v.e_cr_v = CS'(cv);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [DW-1:0] e;
    link.enq__ENA    = v.enq;
    link.enq_v       = v.data;
    link.deq__ENA    = v.deq;
    link.credit__RDY = 1'b1;
    #1;
    chk({tag, ".enq_rdy"},   link.enq__RDY,    v.e_enq_rdy);
    chk({tag, ".first_rdy"}, link.first__RDY,  v.e_first_rdy);
    chk({tag, ".deq_rdy"},   link.deq__RDY,    v.e_first_rdy);
    chk({tag, ".cr_en"},     link.credit__ENA, v.e_cr_en);
    if (v.e_cr_en) chk({tag, ".cr_v"}, link.credit_v, v.e_cr_v);
    if (v.deq && link.deq__RDY) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s.sb: got word %0h expected none", tag, link.first);
      end else begin
        e = sb.pop_front();
        chk({tag, ".first"}, link.first, e);
      end
      tot_deq++;
    end
    if (v.enq && (link.enq__RDY || (v.deq && link.deq__RDY))) begin
      sb.push_back(v.data);
      tot_enq++;
    end
    tick();
    link.enq__ENA = 1'b0;
    link.deq__ENA = 1'b0;
  endtask

  task automatic reset_dut(input logic cr);
    rst              = 1'b1;
    link.enq__ENA    = 1'b0;
    link.deq__ENA    = 1'b0;
    link.enq_v       = '0;
    link.credit__RDY = cr;
    sb.delete();
    tot_enq = 0;
    tot_deq = 0;
    #1;
    chk("rst.cr_en",     link.credit__ENA, 1'b0);
    chk("rst.first_rdy", link.first__RDY,  1'b0);
    chk("rst.deq_rdy",   link.deq__RDY,    1'b0);
    chk("rst.enq_rdy",   link.enq__RDY,    1'b1);
    chk("rst.first",     link.first,       '0);
    chk("rst.overflow",  link.overflow,    1'b0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic chk_inv(input string nm);
    chk(nm, credit_conserved(sb.size(), 0, int'(tot_grant - tot_enq)), 1'b1);
  endtask

  initial begin
    link.enq__ENA    = 1'b0;
    link.deq__ENA    = 1'b0;
    link.enq_v       = '0;
    link.credit__RDY = 1'b1;

    for (int unsigned i = 0; i < 8; i++)
      tbl[i] = mk(1, 32'h10 + i, 0, 1, (i != 0), 0, 0);
    for (int unsigned j = 0; j < 4; j++)
      tbl[8 + j] = mk(0, 0, 1, (j != 0), 1, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 1, 1, 4);
    tbl[13] = mk(0, 0, 0, 1, 1, 0, 0);

    tick();

    // 1: initial grant with sender ready
    reset_dut(1'b1);
    chk("t1.cr_en", link.credit__ENA, 1'b1);
    chk("t1.cr_v",  link.credit_v,    10'd8);
    tick();
    chk("t1.cr_en_after", link.credit__ENA, 1'b0);

    // 2: sender not ready for 5 cycles
    reset_dut(1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("t2.hold", link.credit__ENA, 1'b0);
      tick();
    end
    link.credit__RDY = 1'b1;
    #1;
    chk("t2.cr_en", link.credit__ENA, 1'b1);
    chk("t2.cr_v",  link.credit_v,    10'd8);
    tick();
    chk("t2.cr_en_after", link.credit__ENA, 1'b0);

    // 3: fill, drain four, batch grant
    for (int i = 0; i < 14; i++) apply(tbl[i], "t3");
    chk_inv("t3.inv");

    // 4: partial batch flushed by the idle timer
    for (int i = 0; i < 3; i++) apply(mk(0, 0, 1, 1, 1, 0, 0), "t4.deq");
    for (int i = 0; i < 14; i++) apply(mk(0, 0, 0, 1, 1, 0, 0), "t4.wait");
    apply(mk(0, 0, 0, 1, 1, 1, 3), "t4.flush");
    apply(mk(0, 0, 0, 1, 1, 0, 0), "t4.after");
    chk_inv("t4.inv");

    // 5: grant coincident with an accepted deq
    for (int unsigned i = 0; i < 6; i++) apply(mk(1, 32'h20 + i, 0, 1, 1, 0, 0), "t5.enq");
    for (int i = 0; i < 4; i++) apply(mk(0, 0, 1, 1, 1, 0, 0), "t5.deq");
    apply(mk(0, 0, 1, 1, 1, 1, 4), "t5.grant_deq");
    for (int i = 0; i < 16; i++) apply(mk(0, 0, 0, 1, 1, 0, 0), "t5.carry");
    apply(mk(0, 0, 0, 1, 1, 1, 1), "t5.carry_flush");
    chk("t5.total", tot_grant, tot_deq + 8);
    chk_inv("t5.inv");

    // 6: full, simultaneous enq/deq, overflow, reset mid-stream
    for (int unsigned i = 0; i < 6; i++) apply(mk(1, 32'h30 + i, 0, 1, 1, 0, 0), "t6.fill");
    apply(mk(1, 32'h40, 1, 0, 1, 0, 0), "t6.full_both");
    chk("t6.no_ovf", link.overflow, 1'b0);
    apply(mk(1, 32'h41, 0, 0, 1, 0, 0), "t6.drop");
    chk("t6.ovf", link.overflow, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(mk(0, 0, 0, 0, 1, 0, 0), "t6.hold");
      chk("t6.ovf_sticky", link.overflow, 1'b1);
    end
    for (int i = 0; i < 8; i++)
      apply(mk(0, 0, 1, (i != 0), 1, (i == 3 || i == 7), 4), "t6.drain");
    chk("t6.ovf_end", link.overflow, 1'b1);
    reset_dut(1'b1);
    chk("t6.cr_en", link.credit__ENA, 1'b1);
    chk("t6.cr_v",  link.credit_v,    10'd8);
    tick();

    // deq while empty must not create credit
    apply(mk(0, 0, 1, 1, 0, 0, 0), "t7.empty_deq");
    for (int i = 0; i < 20; i++) apply(mk(0, 0, 0, 1, 0, 0, 0), "t7.quiet");
    chk_inv("t7.inv");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
